// File: rtl/audio_frame_buffer.sv
// Ping-pong stereo-to-mono frame buffer: captures I2S sample pairs as mono frames into
// two banks and presents completed frames to a consumer in capture order.
module audio_frame_buffer #(
  parameter int DATA_BITS = 16,
  parameter int FRAME_LEN = 256,
  localparam int ADDR_BITS = $clog2(FRAME_LEN)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable_i,
  output logic                 i2s_get_o,
  input  logic                 smp_valid_i,
  input  logic [DATA_BITS-1:0] smp_L_i,
  input  logic [DATA_BITS-1:0] smp_R_i,
  output logic                 frame_valid_o,
  output logic                 frame_bank_o,
  input  logic [ADDR_BITS-1:0] rd_addr_i,
  output logic [DATA_BITS-1:0] rd_data_o,
  input  logic                 frame_done_i,
  output logic                 overrun_o
);

  typedef enum logic [1:0] {IDLE, FILL, WAIT} state_t;

  state_t               state, state_n;
  logic [ADDR_BITS-1:0] wr_ptr, wr_ptr_n;
  logic                 wr_bank, wr_bank_n;
  logic                 rd_bank;
  logic [1:0]           full, full_n;
  logic                 overrun, overrun_n;
  logic                 we;
  logic                 rel;
  logic                 wr_bank_busy;
  logic                 other_free;
  logic                 last;
  logic [DATA_BITS:0]   sum;
  logic [DATA_BITS-1:0] mono;

  logic [DATA_BITS-1:0] mem [2*FRAME_LEN];

  // Sign-extended sum cannot overflow; dropping bit 0 is the arithmetic halving.
  assign sum  = {smp_L_i[DATA_BITS-1], smp_L_i} + {smp_R_i[DATA_BITS-1], smp_R_i};
  assign mono = sum[DATA_BITS:1];

  assign rel          = frame_done_i & full[rd_bank];
  assign wr_bank_busy = full[wr_bank] & ~(rel & (rd_bank == wr_bank));
  assign other_free   = ~full[~wr_bank] | (rel & (rd_bank == ~wr_bank));
  assign last         = (wr_ptr == ADDR_BITS'(FRAME_LEN - 1));

  always_comb begin
    state_n   = state;
    wr_ptr_n  = wr_ptr;
    wr_bank_n = wr_bank;
    overrun_n = overrun;
    we        = 1'b0;
    full_n    = full;
    if (rel) full_n[rd_bank] = 1'b0;
    case (state)
      IDLE: begin
        if (enable_i) begin
          state_n   = FILL;
          wr_ptr_n  = '0;
          overrun_n = 1'b0;
        end
      end
      FILL: begin
        if (!enable_i) begin
          state_n  = IDLE;
          wr_ptr_n = '0;
        end else if (smp_valid_i) begin
          // A bank still held from before a disable is never overwritten.
          if (wr_bank_busy) begin
            overrun_n = 1'b1;
          end else begin
            we = 1'b1;
            if (last) begin
              wr_ptr_n        = '0;
              full_n[wr_bank] = 1'b1;
              if (other_free) wr_bank_n = ~wr_bank;
              else            state_n   = WAIT;
            end else begin
              wr_ptr_n = wr_ptr + ADDR_BITS'(1);
            end
          end
        end
      end
      WAIT: begin
        if (!enable_i) begin
          state_n  = IDLE;
          wr_ptr_n = '0;
        end else begin
          if (smp_valid_i) overrun_n = 1'b1;
          if (rel) begin
            state_n   = FILL;
            wr_bank_n = rd_bank;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      full      <= '0;
      overrun   <= 1'b0;
      i2s_get_o <= 1'b0;
      rd_data_o <= '0;
    end else begin
      state     <= state_n;
      wr_ptr    <= wr_ptr_n;
      wr_bank   <= wr_bank_n;
      full      <= full_n;
      overrun   <= overrun_n;
      i2s_get_o <= enable_i;
      rd_data_o <= mem[{rd_bank, rd_addr_i}];
      if (rel) rd_bank <= ~rd_bank;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[{wr_bank, wr_ptr}] <= mono;
  end

  assign frame_valid_o = full[rd_bank];
  assign frame_bank_o  = rd_bank;
  assign overrun_o     = overrun;

endmodule

// File: doc/audio_frame_buffer.md
AUDIO_FRAME_BUFFER -- requirements
Module: audio_frame_buffer

Interface
REQ-001 SHALL have parameter DATA_BITS, default 16, width of one input sample and of one buffered mono sample.
REQ-002 SHALL have parameter FRAME_LEN, default 256, samples per frame; power of two, >= 4.
REQ-003 SHALL have localparam ADDR_BITS = $clog2(FRAME_LEN).
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port enable_i  input  1  capture enable from control logic.
REQ-007 SHALL have port i2s_get_o  output  1  acquisition request to the upstream I2S master.
REQ-008 SHALL have port smp_valid_i  input  1  one-cycle pulse; smp_L_i/smp_R_i valid this cycle.
REQ-009 SHALL have port smp_L_i  input  DATA_BITS  left sample, two's complement.
REQ-010 SHALL have port smp_R_i  input  DATA_BITS  right sample, two's complement.
REQ-011 SHALL have port frame_valid_o  output  1  at least one complete frame awaits the consumer.
REQ-012 SHALL have port frame_bank_o  output  1  index of the bank presented for reading.
REQ-013 SHALL have port rd_addr_i  input  ADDR_BITS  consumer read address within the presented bank.
REQ-014 SHALL have port rd_data_o  output  DATA_BITS  mono sample at rd_addr_i.
REQ-015 SHALL have port frame_done_i  input  1  one-cycle pulse; consumer releases the presented bank.
REQ-016 SHALL have port overrun_o  output  1  sticky flag; a sample was dropped.

Function
REQ-017 SHALL hold two banks (ping-pong) of FRAME_LEN x DATA_BITS storage, each with a full flag.
REQ-018 SHALL compute mono = (sext(L) + sext(R)) >>> 1 on a DATA_BITS+1 wide sum, arithmetic shift, keeping the low DATA_BITS bits; no overflow is possible.
REQ-019 SHALL implement writer FSM states IDLE, FILL, WAIT.
REQ-020 IDLE -> FILL when enable_i = 1; wr_ptr = 0 on entry.
REQ-021 In FILL, on smp_valid_i SHALL write mono to bank wr_bank at wr_ptr and increment wr_ptr.
REQ-022 A write at wr_ptr = FRAME_LEN-1 SHALL set full[wr_bank] and wrap wr_ptr to 0; if the other bank is not full (after same-cycle release), wr_bank toggles and the FSM stays in FILL, else the FSM enters WAIT.
REQ-023 In WAIT, any smp_valid_i sample SHALL be dropped and overrun_o set; WAIT -> FILL on the cycle after a bank is released, with wr_bank = released bank.
REQ-024 FILL or WAIT -> IDLE when enable_i = 0; a partial frame is discarded (wr_ptr = 0); full banks are retained.
REQ-025 i2s_get_o SHALL be enable_i registered (one-cycle latency), independent of FSM state.
REQ-026 frame_valid_o SHALL equal full[rd_bank]; frame_bank_o SHALL equal rd_bank.
REQ-027 Frames SHALL be presented in capture order: rd_bank starts at 0 and toggles only on release.
REQ-028 rd_data_o SHALL be registered: data for rd_addr_i of bank rd_bank appears the next cycle (1-cycle latency).
REQ-029 frame_done_i with frame_valid_o = 1 SHALL clear full[rd_bank] and toggle rd_bank; frame_done_i with frame_valid_o = 0 SHALL be ignored.
REQ-030 Frame completion and frame_done_i in the same cycle SHALL both take effect; the writer continues into the freed bank without entering WAIT.
REQ-031 overrun_o SHALL clear only on reset or on the IDLE -> FILL transition.
REQ-032 smp_valid_i in IDLE SHALL be ignored without setting overrun_o.

Reset
REQ-033 While rst_n = 0 (asynchronously): FSM = IDLE, wr_ptr = 0, wr_bank = 0, rd_bank = 0, both full flags 0, i2s_get_o = 0, frame_valid_o = 0, frame_bank_o = 0, rd_data_o = 0, overrun_o = 0; storage contents need not reset.
REQ-034 Reset asserted mid-frame SHALL discard all buffered data; after release the block stays in IDLE until enable_i = 1.

Verification (FRAME_LEN = 4, DATA_BITS = 16)
REQ-035 enable_i=1, 4 pulses with L=R=0x0010,0x0020,0x0030,0x0040 -> frame_valid_o=1, frame_bank_o=0; reads 0..3 return 0x0010..0x0040 one cycle after address.
REQ-036 L=0x7FFF,R=0x7FFF -> 0x7FFF; L=0x8000,R=0x8000 -> 0x8000; L=0xFFFF,R=0x0000 -> 0xFFFF.
REQ-037 12 samples with no frame_done_i -> banks 0,1 full, FSM WAIT, samples 9..12 dropped, overrun_o=1; frame_done_i -> frame_bank_o=1, next sample written to bank 0 at address 0.
REQ-038 4th sample of bank 1 and frame_done_i for bank 0 in the same cycle -> no WAIT, overrun_o stays 0, 5th sample lands in bank 0.
REQ-039 enable_i dropped after 2 samples, re-raised, 4 samples -> frame holds only the last 4; overrun_o cleared on re-enable.
REQ-040 rst_n pulsed low mid-frame with bank 0 full -> all outputs 0 immediately, frame_valid_o=0 after release.
